// File: rtl/prime_trial_seq.sv
// Trial-division primality sequencer: issues n mod x requests for x = 2, 3, ...
// while x*x <= n and reports primality plus the smallest nontrivial factor.
module prime_trial_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n,
    output logic        busy,
    output logic        done,
    output logic        is_prime,
    output logic [15:0] factor,
    output logic        div_req,
    output logic [15:0] div_n,
    output logic [15:0] div_x,
    input  logic        div_ack,
    input  logic [15:0] div_rem
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REQ,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] nreg_q, nreg_d;
    logic [15:0] x_q, x_d;
    logic [16:0] sq_q, sq_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        is_prime_q, is_prime_d;
    logic [15:0] factor_q, factor_d;
    logic        div_req_q, div_req_d;
    logic [15:0] div_n_q, div_n_d;
    logic [15:0] div_x_q, div_x_d;

    always_comb begin
        state_d    = state_q;
        nreg_d     = nreg_q;
        x_d        = x_q;
        sq_d       = sq_q;
        done_d     = 1'b0;
        is_prime_d = is_prime_q;
        factor_d   = factor_q;
        div_req_d  = div_req_q;
        div_n_d    = div_n_q;
        div_x_d    = div_x_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nreg_d  = n;
                    div_n_d = n;
                    if (n < 16'd2) begin
                        is_prime_d = 1'b0;
                        factor_d   = 16'd0;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else if (n < 16'd4) begin
                        is_prime_d = 1'b1;
                        factor_d   = 16'd0;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        x_d     = 16'd2;
                        sq_d    = 17'd4;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (sq_q > {1'b0, nreg_q}) begin
                    is_prime_d = 1'b1;
                    factor_d   = 16'd0;
                    state_d    = DONE;
                end else begin
                    div_req_d = 1'b1;
                    div_x_d   = x_q;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (div_ack) begin
                    div_req_d = 1'b0;
                    if (div_rem == 16'd0) begin
                        is_prime_d = 1'b0;
                        factor_d   = x_q;
                        state_d    = DONE;
                    end else begin
                        // (x+1)^2 = x^2 + 2x + 1
                        sq_d    = sq_q + {x_q, 1'b1};
                        x_d     = x_q + 16'd1;
                        state_d = CHECK;
                    end
                end
            end
            DONE: begin
                // Looped results land one cycle ahead of the done pulse.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            nreg_q     <= 16'd0;
            x_q        <= 16'd0;
            sq_q       <= 17'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            is_prime_q <= 1'b0;
            factor_q   <= 16'd0;
            div_req_q  <= 1'b0;
            div_n_q    <= 16'd0;
            div_x_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            nreg_q     <= nreg_d;
            x_q        <= x_d;
            sq_q       <= sq_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            is_prime_q <= is_prime_d;
            factor_q   <= factor_d;
            div_req_q  <= div_req_d;
            div_n_q    <= div_n_d;
            div_x_q    <= div_x_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign is_prime = is_prime_q;
    assign factor   = factor_q;
    assign div_req  = div_req_q;
    assign div_n    = div_n_q;
    assign div_x    = div_x_q;

endmodule

// File: tb/tb_prime_trial_seq.sv
// Bench for prime_trial_seq: divider model with configurable stall, vector
// table, randomized candidates against an arithmetic reference, reset cases.
module tb_prime_trial_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n;
    logic        busy, done, is_prime, div_req;
    logic [15:0] factor, div_n, div_x;
    logic        div_ack = 1'b0;
    logic [15:0] div_rem = 16'd0;

    prime_trial_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n       (n),
        .busy    (busy),
        .done    (done),
        .is_prime(is_prime),
        .factor  (factor),
        .div_req (div_req),
        .div_n   (div_n),
        .div_x   (div_x),
        .div_ack (div_ack),
        .div_rem (div_rem)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Divider model state
    int          dly       = 0;
    bit          hold      = 1'b0;
    bit          force_ack = 1'b0;
    bit          active    = 1'b0;
    int          cnt       = 0;
    int          stab_err  = 0;
    logic [15:0] lx, ln;
    logic [15:0] cur_n     = 16'd0;
    int          xq[$];

    always @(negedge clk) begin
        if (force_ack) begin
            div_ack = 1'b1;
            div_rem = 16'd0;
        end else if (div_req) begin
            if (!active) begin
                active = 1'b1;
                cnt    = 0;
                lx     = div_x;
                ln     = div_n;
                xq.push_back(int'(div_x));
            end else begin
                cnt++;
                if (div_x !== lx || div_n !== ln) stab_err++;
            end
            if (div_n !== cur_n) stab_err++;
            if (!hold && cnt == dly) begin
                div_ack = 1'b1;
                div_rem = (div_x == 16'd0) ? 16'd0 : div_n % div_x;
                active  = 1'b0;
            end else begin
                div_ack = 1'b0;
                div_rem = 16'($urandom);
            end
        end else begin
            div_ack = hold ? 1'b0 : 1'($urandom);
            div_rem = 16'($urandom);
            active  = 1'b0;
        end
    end

    function automatic void model(input int v, output bit p,
                                  output int f, output int k);
        p = 1'b0;
        f = 0;
        k = 0;
        if (v < 2) return;
        for (int d = 2; d * d <= v; d++) begin
            k++;
            if (v % d == 0) begin
                f = d;
                return;
            end
        end
        p = 1'b1;
    endfunction

    task automatic run(input logic [15:0] nv, input int d, input int mid,
                       input bit ep, input int ef, input int ek,
                       input int el, input string tag);
        int e;
        int bad;
        dly      = d;
        cur_n    = nv;
        stab_err = 0;
        xq.delete();
        @(negedge clk);
        start = 1'b1;
        n     = nv;
        @(negedge clk);
        start = 1'b0;
        n     = 16'($urandom);
        e     = 0;
        chk({tag, " busy"}, int'(busy), 1);
        while (!done && e < 3000) begin
            @(negedge clk);
            e++;
            start = (e == mid);
            if (e == mid) n = 16'd7;
        end
        start = 1'b0;
        chk({tag, " latency"}, e, el);
        chk({tag, " is_prime"}, int'(is_prime), int'(ep));
        chk({tag, " factor"}, int'(factor), ef);
        chk({tag, " requests"}, xq.size(), ek);
        bad = 0;
        foreach (xq[i]) if (xq[i] != i + 2) bad++;
        chk({tag, " divisor_seq"}, bad, 0);
        chk({tag, " req_stable"}, stab_err, 0);
        @(negedge clk);
        chk({tag, " done_drop"}, int'(done), 0);
        chk({tag, " busy_drop"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [15:0] n;
        int          d;
        int          mid;
        bit          p;
        int          f;
        int          k;
        int          l;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit rp;
        int rf, rk, rd, rl, w;
        logic [15:0] rv;

        tbl[0]  = '{16'd0,     0, -1, 1'b0, 0, 0,   0};
        tbl[1]  = '{16'd1,     0, -1, 1'b0, 0, 0,   0};
        tbl[2]  = '{16'd2,     0, -1, 1'b1, 0, 0,   0};
        tbl[3]  = '{16'd3,     0, -1, 1'b1, 0, 0,   0};
        tbl[4]  = '{16'd97,    0, -1, 1'b1, 0, 8,   18};
        tbl[5]  = '{16'd91,    0, -1, 1'b0, 7, 6,   13};
        tbl[6]  = '{16'd65535, 0, -1, 1'b0, 3, 2,   5};
        tbl[7]  = '{16'd4,     0, -1, 1'b0, 2, 1,   3};
        tbl[8]  = '{16'd5,     0, -1, 1'b1, 0, 1,   4};
        tbl[9]  = '{16'd25,    1, -1, 1'b0, 5, 4,   13};
        tbl[10] = '{16'd65521, 3, 100, 1'b1, 0, 254, 1272};
        tbl[11] = '{16'd9,     2, -1, 1'b0, 3, 2,   9};

        rst   = 1'b1;
        start = 1'b0;
        n     = 16'd0;
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset is_prime", int'(is_prime), 0);
        chk("reset factor", int'(factor), 0);
        chk("reset div_req", int'(div_req), 0);
        chk("reset div_n", int'(div_n), 0);
        chk("reset div_x", int'(div_x), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i])
            run(tbl[i].n, tbl[i].d, tbl[i].mid, tbl[i].p, tbl[i].f,
                tbl[i].k, tbl[i].l, $sformatf("vec%0d n=%0d", i, tbl[i].n));

        for (int i = 0; i < 30; i++) begin
            rv = (i % 2 == 0) ? 16'($urandom_range(0, 400)) : 16'($urandom);
            rd = $urandom_range(0, 1);
            model(int'(rv), rp, rf, rk);
            if (rv < 16'd4) rl = 0;
            else rl = (rp ? 2 * rk + 2 : 2 * rk + 1) + rk * rd;
            run(rv, rd, -1, rp, rf, rk, rl, $sformatf("rnd%0d n=%0d", i, rv));
        end

        // Reset while a request is outstanding
        hold  = 1'b1;
        cur_n = 16'd91;
        @(negedge clk);
        start = 1'b1;
        n     = 16'd91;
        @(negedge clk);
        start = 1'b0;
        w     = 0;
        while (!div_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid req_seen", int'(div_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid div_req", int'(div_req), 0);
        chk("rst_mid busy", int'(busy), 0);
        chk("rst_mid done", int'(done), 0);
        @(negedge clk);
        rst       = 1'b0;
        hold      = 1'b0;
        force_ack = 1'b1;
        w         = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done || div_req) w++;
        end
        force_ack = 1'b0;
        chk("rst_mid late_ack_ignored", w, 0);
        run(16'd49, 0, -1, 1'b0, 7, 6, 13, "after_rst n=49");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
